valid_stream_collector: RTL and testbench

Receiving end of the valid-only filter stream. The upstream filter chain presents a word on `io_in_bits` whenever `io_in_valid` is high and cannot be stalled. This block captures every such word into a small FIFO and re-presents it as a ready/valid (decoupled) stream to a consumer that can apply backpressure. Words arriving while the FIFO is full are dropped and counted.

---
 rtl/stream_pkg.sv | 10 +
 rtl/stream_fifo_mem.sv | 27 ++
 rtl/valid_stream_collector.sv | 80 ++++++++
 tb/tb_valid_stream_collector.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared constants for the valid-only filter stream and its receiving FIFO.
package stream_pkg;

    localparam int unsigned STREAM_W = 16;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module stream_fifo_mem
    import stream_pkg::*;
#(
    parameter int unsigned WIDTH = STREAM_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      i_we,
    input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
    output logic [WIDTH-1:0]          o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage has no reset; stale contents are never exposed because occupancy is cleared.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/valid_stream_collector.sv
// Captures an unstallable valid-only stream into a FIFO and re-presents it as ready/valid;
// overflow words are dropped and counted with a saturating counter.
module valid_stream_collector
    import stream_pkg::*;
#(
    parameter int unsigned WIDTH  = STREAM_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_in_valid,
    input  logic [WIDTH-1:0]        io_in_bits,
    input  logic                    io_out_ready,
    output logic                    io_out_valid,
    output logic [WIDTH-1:0]        io_out_bits,
    output logic [ptr_w(DEPTH):0]   io_count,
    output logic [DROP_W-1:0]       io_dropped
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DROP_W-1:0] r_dropped;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // A same-cycle pop frees a slot, so a full FIFO still accepts when the consumer is ready.
    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_pop  = io_out_valid & io_out_ready;
    assign w_push = io_in_valid & (~w_full | w_pop);
    assign w_drop = io_in_valid & w_full & ~w_pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_dropped <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_dropped != {DROP_W{1'b1}})) begin
                r_dropped <= r_dropped + DROP_W'(1);
            end
        end
    end

    stream_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (io_in_bits),
        .i_raddr (r_rd_ptr),
        .o_rdata (io_out_bits)
    );

    assign io_out_valid = (r_count != '0);
    assign io_count     = r_count;
    assign io_dropped   = r_dropped;

endmodule

// File: tb/tb_valid_stream_collector.sv
// Scoreboard bench for valid_stream_collector (WIDTH=16, DEPTH=4, DROP_W=8).
module tb_valid_stream_collector;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_in_valid = 1'b0;
    logic [15:0] io_in_bits = '0;
    logic        io_out_ready = 1'b0;
    logic        io_out_valid;
    logic [15:0] io_out_bits;
    logic [2:0]  io_count;
    logic [7:0]  io_dropped;

    valid_stream_collector #(
        .WIDTH  (16),
        .DEPTH  (DEPTH),
        .DROP_W (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_bits   (io_in_bits),
        .io_out_ready (io_out_ready),
        .io_out_valid (io_out_valid),
        .io_out_bits  (io_out_bits),
        .io_count     (io_count),
        .io_dropped   (io_dropped)
    );

    always #5 clock = ~clock;

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    int unsigned  n_rx  = 0;
    int unsigned  m_count = 0;
    int unsigned  m_drop  = 0;
    logic [15:0]  sb [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then drive this cycle's inputs.
    task automatic step(input logic v, input logic [15:0] d, input logic rdy);
        logic pop;
        logic push;
        @(negedge clock);
        chk("out_valid", 32'(io_out_valid), 32'(m_count != 0));
        chk("count", 32'(io_count), m_count);
        chk("dropped", 32'(io_dropped), m_drop);
        if (m_count != 0 && sb.size() != 0) begin
            chk("out_bits", 32'(io_out_bits), 32'(sb[0]));
        end
        io_in_valid  = v;
        io_in_bits   = d;
        io_out_ready = rdy;
        pop  = (m_count != 0) && rdy;
        push = v && ((m_count < DEPTH) || pop);
        if (pop) begin
            void'(sb.pop_front());
            n_rx++;
            m_count--;
        end
        if (push) begin
            sb.push_back(d);
            m_count++;
        end
        if (v && !push && m_drop < 255) begin
            m_drop++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h0, 1'b1);
        end
    endtask

    int unsigned rx_base;

    initial begin
        #3;
        chk("rst_valid", 32'(io_out_valid), 32'd0);
        chk("rst_count", 32'(io_count), 32'd0);
        chk("rst_dropped", 32'(io_dropped), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Single word with 1-cycle latency.
        step(1'b1, 16'h0004, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        chk("single_valid", 32'(io_out_valid), 32'd1);
        chk("single_bits", 32'(io_out_bits), 32'h0004);
        chk("single_count", 32'(io_count), 32'd1);
        step(1'b0, 16'h0000, 1'b1);
        chk("single_empty", 32'(io_count), 32'd0);

        // Fill with stalled consumer; fifth word overflows.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'(2 * i), 1'b0);
        end
        step(1'b0, 16'h0, 1'b0);
        chk("fill_count", 32'(io_count), 32'd4);
        chk("fill_dropped", 32'(io_dropped), 32'd1);
        step(1'b0, 16'h0, 1'b0);
        chk("stall_bits", 32'(io_out_bits), 32'h0000);

        // Full with simultaneous pop: incoming word is accepted.
        step(1'b1, 16'h0006, 1'b1);
        step(1'b0, 16'h0, 1'b0);
        chk("fullpop_count", 32'(io_count), 32'd4);
        chk("fullpop_dropped", 32'(io_dropped), 32'd1);
        drain();
        chk("drain_empty", 32'(io_out_valid), 32'd0);

        // Drop counter saturation.
        for (int i = 0; i < 4 + 300; i++) begin
            step(1'b1, 16'(i), 1'b0);
        end
        step(1'b0, 16'h0, 1'b0);
        chk("sat_dropped", 32'(io_dropped), 32'd255);
        step(1'b1, 16'hbeef, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        chk("sat_hold", 32'(io_dropped), 32'd255);
        drain();

        // Pointer wrap with toggling ready.
        rx_base = n_rx;
        for (int c = 0; c < 20; c++) begin
            step((c % 2) == 0, 16'(c), (c % 2) == 1);
        end
        drain();
        chk("wrap_rx", n_rx - rx_base, 32'd10);
        chk("wrap_nodrop", 32'(io_dropped), 32'd255);

        // Asynchronous reset mid-stream with three words held.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'(16'h0100 + 16'(i)), 1'b0);
        end
        step(1'b0, 16'h0, 1'b0);
        chk("pre_rst_count", 32'(io_count), 32'd3);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(io_out_valid), 32'd0);
        chk("arst_count", 32'(io_count), 32'd0);
        chk("arst_dropped", 32'(io_dropped), 32'd0);
        sb.delete();
        m_count = 0;
        m_drop  = 0;
        @(negedge clock);
        reset = 1'b1;
        step(1'b1, 16'h1234, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        chk("post_rst_bits", 32'(io_out_bits), 32'h1234);
        drain();
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
